// File: rtl/hardcloud_seq_pkg.sv
// Shared types and widths for the kernel sequencer and its chunk generator.
package hardcloud_seq_pkg;

  localparam int unsigned CMD_BYTES_W           = 32;
  localparam int unsigned MAX_OUTSTANDING_LIMIT = 15;
  // Sized for the largest legal MAX_OUTSTANDING so any configuration fits.
  localparam int unsigned OUTSTANDING_W         = $clog2(MAX_OUTSTANDING_LIMIT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StDrain,
    StDone
  } seq_state_e;

endpackage

// File: rtl/hardcloud_chunk_gen.sv
// Tracks the remaining byte count and both chunk pointers; yields the current chunk
// length and steps all three forward by one chunk on advance_i.
module hardcloud_chunk_gen
  import hardcloud_seq_pkg::*;
#(
  parameter int unsigned CHUNK_BYTES = 4096,
  parameter int unsigned ADDR_W      = 64
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   load_i,
  input  logic [CMD_BYTES_W-1:0] xfer_bytes_i,
  input  logic [ADDR_W-1:0]      src_ptr_i,
  input  logic [ADDR_W-1:0]      dst_ptr_i,
  input  logic                   advance_i,
  output logic [CMD_BYTES_W-1:0] chunk_bytes_o,
  output logic [ADDR_W-1:0]      rd_addr_o,
  output logic [ADDR_W-1:0]      wr_addr_o,
  output logic                   last_o
);

  localparam logic [CMD_BYTES_W-1:0] ChunkLen = CMD_BYTES_W'(CHUNK_BYTES);

  logic [CMD_BYTES_W-1:0] remaining_q, remaining_d;
  logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [CMD_BYTES_W-1:0] chunk;

  assign chunk         = (remaining_q < ChunkLen) ? remaining_q : ChunkLen;
  assign chunk_bytes_o = chunk;
  assign rd_addr_o     = rd_addr_q;
  assign wr_addr_o     = wr_addr_q;
  assign last_o        = (remaining_q == chunk);

  always_comb begin
    remaining_d = remaining_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    if (load_i) begin
      remaining_d = xfer_bytes_i;
      rd_addr_d   = src_ptr_i;
      wr_addr_d   = dst_ptr_i;
    end else if (advance_i) begin
      // Pointer sums wrap naturally at 2^ADDR_W.
      remaining_d = remaining_q - chunk;
      rd_addr_d   = rd_addr_q + ADDR_W'(chunk);
      wr_addr_d   = wr_addr_q + ADDR_W'(chunk);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      remaining_q <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
    end else begin
      remaining_q <= remaining_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

endmodule

// File: rtl/hardcloud_kernel_sequencer.sv
// Runs one kernel transfer: splits it into chunks, issues paired read/write commands
// with bounded outstanding writes, and pulses ap_done once every write has completed.
module hardcloud_kernel_sequencer
  import hardcloud_seq_pkg::*;
#(
  parameter int unsigned CHUNK_BYTES     = 4096,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_W          = 64
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   ap_start,
  output logic                   ap_done,
  output logic                   ap_idle,
  input  logic [CMD_BYTES_W-1:0] xfer_bytes,
  input  logic [ADDR_W-1:0]      src_ptr,
  input  logic [ADDR_W-1:0]      dst_ptr,
  output logic                   rd_cmd_valid,
  input  logic                   rd_cmd_ready,
  output logic [ADDR_W-1:0]      rd_cmd_addr,
  output logic [CMD_BYTES_W-1:0] rd_cmd_bytes,
  output logic                   wr_cmd_valid,
  input  logic                   wr_cmd_ready,
  output logic [ADDR_W-1:0]      wr_cmd_addr,
  output logic [CMD_BYTES_W-1:0] wr_cmd_bytes,
  input  logic                   wr_done
);

  localparam logic [OUTSTANDING_W-1:0] MaxOut = OUTSTANDING_W'(MAX_OUTSTANDING);

  seq_state_e               state_q, state_d;
  logic                     rd_acc_q, rd_acc_d;
  logic                     wr_acc_q, wr_acc_d;
  logic [OUTSTANDING_W-1:0] out_q, out_d;

  logic                   load, issue, rd_hs, wr_hs, done_ok, last;
  logic [CMD_BYTES_W-1:0] chunk_bytes;

  hardcloud_chunk_gen #(
    .CHUNK_BYTES (CHUNK_BYTES),
    .ADDR_W      (ADDR_W)
  ) u_chunk_gen (
    .aclk          (aclk),
    .areset        (areset),
    .load_i        (load),
    .xfer_bytes_i  (xfer_bytes),
    .src_ptr_i     (src_ptr),
    .dst_ptr_i     (dst_ptr),
    .advance_i     (issue),
    .chunk_bytes_o (chunk_bytes),
    .rd_addr_o     (rd_cmd_addr),
    .wr_addr_o     (wr_cmd_addr),
    .last_o        (last)
  );

  assign rd_cmd_bytes = chunk_bytes;
  assign wr_cmd_bytes = chunk_bytes;

  // Each valid drops on its own handshake; the chunk counts as issued once both are in.
  assign rd_cmd_valid = (state_q == StIssue) && !rd_acc_q;
  assign wr_cmd_valid = (state_q == StIssue) && !wr_acc_q;
  assign rd_hs        = rd_cmd_valid && rd_cmd_ready;
  assign wr_hs        = wr_cmd_valid && wr_cmd_ready;
  assign issue        = (state_q == StIssue) && (rd_acc_q || rd_hs) && (wr_acc_q || wr_hs);
  assign done_ok      = wr_done && (out_q != '0) &&
                        (state_q inside {StIssue, StWait, StDrain});
  assign out_d        = load ? '0 : out_q + OUTSTANDING_W'(issue) - OUTSTANDING_W'(done_ok);

  always_comb begin
    state_d  = state_q;
    rd_acc_d = rd_acc_q;
    wr_acc_d = wr_acc_q;
    load     = 1'b0;
    ap_idle  = 1'b0;
    ap_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          load    = 1'b1;
          state_d = (xfer_bytes == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        rd_acc_d = rd_acc_q || rd_hs;
        wr_acc_d = wr_acc_q || wr_hs;
        if (issue) begin
          rd_acc_d = 1'b0;
          wr_acc_d = 1'b0;
          if (last) begin
            state_d = StDrain;
          end else if (out_d >= MaxOut) begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (out_d < MaxOut) state_d = StIssue;
      end
      StDrain: begin
        if (out_d == '0) state_d = StDone;
      end
      StDone: begin
        ap_done = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= StIdle;
      rd_acc_q <= 1'b0;
      wr_acc_q <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_acc_q <= rd_acc_d;
      wr_acc_q <= wr_acc_d;
      out_q    <= out_d;
    end
  end

endmodule

// File: tb/tb_hardcloud_kernel_sequencer.sv
// Bench for the kernel sequencer: behavioural DMA engines, a chunk-list reference model,
// table vectors, directed corner sequences and randomized runs.
module tb_hardcloud_kernel_sequencer;

  localparam int unsigned CHUNK   = 4096;
  localparam int unsigned MAX_OUT = 4;

  logic        aclk = 1'b0;
  logic        areset;
  logic        ap_start, ap_done, ap_idle;
  logic [31:0] xfer_bytes;
  logic [63:0] src_ptr, dst_ptr;
  logic        rd_cmd_valid, rd_cmd_ready, wr_cmd_valid, wr_cmd_ready, wr_done;
  logic [63:0] rd_cmd_addr, wr_cmd_addr;
  logic [31:0] rd_cmd_bytes, wr_cmd_bytes;

  hardcloud_kernel_sequencer #(
    .CHUNK_BYTES     (CHUNK),
    .MAX_OUTSTANDING (MAX_OUT),
    .ADDR_W          (64)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .ap_start     (ap_start),
    .ap_done      (ap_done),
    .ap_idle      (ap_idle),
    .xfer_bytes   (xfer_bytes),
    .src_ptr      (src_ptr),
    .dst_ptr      (dst_ptr),
    .rd_cmd_valid (rd_cmd_valid),
    .rd_cmd_ready (rd_cmd_ready),
    .rd_cmd_addr  (rd_cmd_addr),
    .rd_cmd_bytes (rd_cmd_bytes),
    .wr_cmd_valid (wr_cmd_valid),
    .wr_cmd_ready (wr_cmd_ready),
    .wr_cmd_addr  (wr_cmd_addr),
    .wr_cmd_bytes (wr_cmd_bytes),
    .wr_done      (wr_done)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] bytes;
  } cmd_t;

  typedef struct {
    int unsigned xfer;
    logic [63:0] src;
    logic [63:0] dst;
    int          wr_dly;
    int          done_dly;
    int unsigned exp_chunks;
    int unsigned exp_last;
  } vec_t;

  int checks = 0;
  int errors = 0;

  cmd_t rd_log[$];
  cmd_t wr_log[$];
  int   due_q[$];
  int   cyc, pairs, dones, max_out, stab_err, rd_vcyc, wr_vcyc, wv_cnt;
  int   done_cyc, last_done_cyc, dones_at_done, wait_steps;
  bit   done_seen, rd_pend, wr_pend, rd_rand;
  int   wr_delay, done_dly, done_credit;
  logic [95:0] rd_prev, wr_prev;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic monitor();
    bit rd_acc, wr_acc;
    if (areset) begin
      rd_pend = 0;
      wr_pend = 0;
      return;
    end
    rd_acc = rd_cmd_valid && rd_cmd_ready;
    wr_acc = wr_cmd_valid && wr_cmd_ready;
    if (rd_pend && (!rd_cmd_valid || {rd_cmd_addr, rd_cmd_bytes} != rd_prev)) stab_err++;
    if (wr_pend && (!wr_cmd_valid || {wr_cmd_addr, wr_cmd_bytes} != wr_prev)) stab_err++;
    rd_pend = rd_cmd_valid && !rd_acc;
    wr_pend = wr_cmd_valid && !wr_acc;
    rd_prev = {rd_cmd_addr, rd_cmd_bytes};
    wr_prev = {wr_cmd_addr, wr_cmd_bytes};
    if (rd_cmd_valid) rd_vcyc++;
    if (wr_cmd_valid) wr_vcyc++;
    if (rd_acc) rd_log.push_back('{rd_cmd_addr, rd_cmd_bytes});
    if (wr_acc) begin
      wr_log.push_back('{wr_cmd_addr, wr_cmd_bytes});
      wv_cnt = 0;
    end else if (wr_cmd_valid) begin
      wv_cnt++;
    end else begin
      wv_cnt = 0;
    end
    // A chunk is in flight once both its read and write have been accepted.
    while (pairs < rd_log.size() && pairs < wr_log.size()) begin
      pairs++;
      due_q.push_back(cyc + done_dly);
    end
    if (wr_done) begin
      dones++;
      last_done_cyc = cyc;
    end
    if (pairs - dones > max_out) max_out = pairs - dones;
    if (ap_done) begin
      done_seen     = 1;
      done_cyc      = cyc;
      dones_at_done = dones;
    end
  endtask

  task automatic drive();
    rd_cmd_ready = rd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (wr_delay < 0) wr_cmd_ready = 1'($urandom_range(0, 1));
    else              wr_cmd_ready = (wv_cnt >= wr_delay);
    wr_done = 1'b0;
    if (done_credit != 0 && due_q.size() > 0 && due_q[0] <= cyc) begin
      wr_done = 1'b1;
      void'(due_q.pop_front());
      if (done_credit > 0) done_credit--;
    end
  endtask

  task automatic step();
    @(negedge aclk);
    monitor();
    @(posedge aclk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic clear();
    rd_log.delete();
    wr_log.delete();
    due_q.delete();
    pairs = 0; dones = 0; max_out = 0; stab_err = 0; rd_vcyc = 0; wr_vcyc = 0; wv_cnt = 0;
    done_seen = 0; rd_pend = 0; wr_pend = 0; done_credit = -1;
    done_cyc = 0; last_done_cyc = 0; dones_at_done = 0;
  endtask

  task automatic start(input int unsigned n, input logic [63:0] s, input logic [63:0] d);
    xfer_bytes = n;
    src_ptr    = s;
    dst_ptr    = d;
    ap_start   = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    wait_steps = 0;
    while (!done_seen && wait_steps < budget) begin
      step();
      wait_steps++;
    end
    ap_start = 1'b0;
  endtask

  // Reference: the expected command list follows directly from byte count and chunk size.
  task automatic check_run(input int unsigned n, input logic [63:0] s, input logic [63:0] d,
                           input string tag);
    int unsigned nc, len;
    logic [63:0] off;
    nc = (n + CHUNK - 1) / CHUNK;
    check({tag, "_done_seen"}, 64'(done_seen), 64'd1);
    check({tag, "_idle_after"}, 64'(ap_idle), 64'd1);
    check({tag, "_rd_count"}, 64'(rd_log.size()), 64'(nc));
    check({tag, "_wr_count"}, 64'(wr_log.size()), 64'(nc));
    for (int i = 0; i < int'(nc); i++) begin
      off = 64'(i) * 64'(CHUNK);
      len = (i == int'(nc) - 1) ? n - 32'(i) * CHUNK : CHUNK;
      if (i < rd_log.size()) begin
        check({tag, "_rd_addr"}, rd_log[i].addr, s + off);
        check({tag, "_rd_len"}, 64'(rd_log[i].bytes), 64'(len));
      end
      if (i < wr_log.size()) begin
        check({tag, "_wr_addr"}, wr_log[i].addr, d + off);
        check({tag, "_wr_len"}, 64'(wr_log[i].bytes), 64'(len));
      end
    end
    check({tag, "_dones_at_done"}, 64'(dones_at_done), 64'(nc));
    if (nc > 0) check({tag, "_done_latency"}, 64'(done_cyc - last_done_cyc), 64'd1);
    check({tag, "_outstanding_bound"}, 64'(max_out <= int'(MAX_OUT)), 64'd1);
    check({tag, "_payload_stable"}, 64'(stab_err), 64'd0);
  endtask

  task automatic run_xfer(input int unsigned n, input logic [63:0] s, input logic [63:0] d,
                          input string tag);
    clear();
    start(n, s, d);
    wait_done(4000);
    check_run(n, s, d, tag);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{10000, 64'h1000_0000, 64'h2000_0000, 0, 5, 3, 1808};
    vecs[1] = '{4096, 64'h0000_8000, 64'h0009_0000, 0, 1, 1, 4096};
    vecs[2] = '{100, 64'h0000_3000, 64'h0004_0000, 1, 2, 1, 100};
    vecs[3] = '{4097, 64'h0001_0000, 64'h0002_0000, 0, 3, 2, 1};
    vecs[4] = '{8192, 64'hFFFF_FFFF_FFFF_F000, 64'h5000, 0, 2, 2, 4096};
    vecs[5] = '{12288, 64'h7000, 64'hA000, 2, 9, 3, 4096};

    areset = 1'b1; ap_start = 1'b0; xfer_bytes = '0; src_ptr = '0; dst_ptr = '0;
    rd_cmd_ready = 1'b0; wr_cmd_ready = 1'b0; wr_done = 1'b0;
    cyc = 0; rd_rand = 0; wr_delay = 0; done_dly = 5;
    clear();
    repeat (3) step();
    areset = 1'b0;
    step();
    check("reset_idle", 64'(ap_idle), 64'd1);
    check("reset_done", 64'(ap_done), 64'd0);
    check("reset_valids", 64'({rd_cmd_valid, wr_cmd_valid}), 64'd0);
    check("reset_payload", {rd_cmd_addr | wr_cmd_addr}, 64'd0);
    check("reset_bytes", 64'({rd_cmd_bytes, wr_cmd_bytes}), 64'd0);

    // Zero-length run: done without any command.
    run_xfer(0, 64'h1000, 64'h2000, "zero");
    check("zero_done_steps", 64'(wait_steps), 64'd2);
    check("zero_no_valid", 64'(rd_vcyc + wr_vcyc), 64'd0);

    foreach (vecs[k]) begin
      wr_delay = vecs[k].wr_dly;
      done_dly = vecs[k].done_dly;
      run_xfer(vecs[k].xfer, vecs[k].src, vecs[k].dst, $sformatf("vec%0d", k));
      check("vec_chunks", 64'(rd_log.size()), 64'(vecs[k].exp_chunks));
      if (rd_log.size() > 0)
        check("vec_last_len", 64'(rd_log[rd_log.size()-1].bytes), 64'(vecs[k].exp_last));
    end

    // Completions withheld: stall at the outstanding limit, one release lets one more out.
    wr_delay = 0; done_dly = 1;
    clear();
    done_credit = 0;
    start(8 * CHUNK, 64'h4000_0000, 64'h6000_0000);
    repeat (30) step();
    check("hold_rd_count", 64'(rd_log.size()), 64'(MAX_OUT));
    check("hold_wr_count", 64'(wr_log.size()), 64'(MAX_OUT));
    check("hold_busy", 64'({ap_idle, rd_cmd_valid, wr_cmd_valid}), 64'd0);
    done_credit = 1;
    repeat (10) step();
    check("release_one_count", 64'(wr_log.size()), 64'(MAX_OUT + 1));
    check("release_one_dones", 64'(dones), 64'd1);
    done_credit = -1;
    wait_done(2000);
    check_run(8 * CHUNK, 64'h4000_0000, 64'h6000_0000, "hold");

    // Write engine slow to accept: read valid lasts one cycle, write payload holds.
    wr_delay = 7; done_dly = 2;
    run_xfer(2 * CHUNK, 64'h9000, 64'hB000, "slow_wr");
    check("slow_wr_rd_valid_cycles", 64'(rd_vcyc), 64'd2);
    check("slow_wr_wr_valid_cycles", 64'(wr_vcyc), 64'd16);

    // Dense traffic with short completion delay exercises issue coincident with wr_done.
    wr_delay = 0; done_dly = 3;
    run_xfer(16 * CHUNK, 64'h10_0000, 64'h20_0000, "coinc");

    // Reset mid-run with two chunks in flight, then a stray completion, then a clean run.
    wr_delay = 0; done_dly = 1;
    clear();
    done_credit = 0;
    start(8 * CHUNK, 64'h1_0000, 64'h2_0000);
    for (int i = 0; i < 50 && pairs < 2; i++) step();
    check("mid_reset_pairs", 64'(pairs), 64'd2);
    areset = 1'b1;
    ap_start = 1'b0;
    step();
    check("mid_reset_idle", 64'(ap_idle), 64'd1);
    check("mid_reset_valids", 64'({rd_cmd_valid, wr_cmd_valid, ap_done}), 64'd0);
    areset = 1'b0;
    clear();
    due_q.push_back(0);
    step();
    step();
    check("stray_done_idle", 64'(ap_idle), 64'd1);
    check("stray_done_valids", 64'({rd_cmd_valid, wr_cmd_valid}), 64'd0);
    run_xfer(CHUNK, 64'h3_0000, 64'h4_0000, "after_reset");

    // Randomized runs: random sizes, pointers, ready patterns and completion delays.
    rd_rand = 1;
    for (int r = 0; r < 10; r++) begin
      int unsigned n;
      logic [63:0] s, d;
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 200) : $urandom_range(1, 7 * CHUNK);
      s = {$urandom, $urandom} & ~64'hFFF;
      d = {$urandom, $urandom} & ~64'hFFF;
      wr_delay = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 3));
      done_dly = $urandom_range(1, 9);
      run_xfer(n, s, d, $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
